// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter-facing signal bundle for uart_tx_queue.
// The master side is the environment; the slave side is the queue itself.
interface uart_tx_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, level, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, level, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO and launch sequencer feeding an 8N1 UART transmitter's start/data/busy handshake.
// Define UART_TXQ_DROP_CNT_EN to add a 16-bit saturating count of pushes dropped while full.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_queue_if.slave  bus
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [15:0]     drop_cnt
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state, state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_q, level_next;
    logic                  full_q, empty_q;
    logic [1:0]            wait_cnt, wait_cnt_next;
    logic                  tx_start_q, tx_start_next;
    logic [7:0]            tx_data_q, tx_data_next;
    logic                  push, pop;

    // Full is judged on the registered level, so a push in a pop cycle while full is dropped.
    assign push       = bus.wr_en && !full_q;
    assign level_next = level_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_q;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q && !bus.tx_busy) begin
                    pop           = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = mem[rd_ptr];
                    wait_cnt_next = 2'd0;
                    state_next    = WAIT_BUSY;
                end
            end
            // Give up after four cycles without busy so a lost launch cannot wedge the queue.
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_cnt == 2'd3) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            tx_start_q <= tx_start_next;
            tx_data_q  <= tx_data_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level_q <= level_next;
            full_q  <= (level_next == LVL_FULL);
            empty_q <= (level_next == '0);
        end
    end

    // Storage carries no reset; a byte is only readable once level counts it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'h0000;
        end else if (bus.wr_en && full_q && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: behavioural transmitter stand-in plus a queue-based reference model.
// Builds with or without UART_TXQ_DROP_CNT_EN.
module tb_uart_tx_queue;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic rst_n;
    uart_tx_queue_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();
`ifdef UART_TXQ_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef UART_TXQ_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: byte queue plus "sequencer free" bookkeeping.
    logic [7:0] m_q[$];
    bit         m_free      = 1'b1;
    int         m_age       = 0;
    bit         m_busy_seen = 1'b0;
    bit         exp_start   = 1'b0;
    logic [7:0] exp_data    = 8'h00;
`ifdef UART_TXQ_DROP_CNT_EN
    int         m_drops     = 0;
`endif

    // Transmitter stand-in: busy rises the cycle after tx_start, for a frame_min..frame_max cycle frame.
    bit         tx_connected = 1'b1;
    int         tx_rem       = 0;
    int         frame_min    = 4;
    int         frame_max    = 4;
    int         last_fall    = -100;
    logic [7:0] rx_q[$];

    function automatic bit model_will_pop();
        return m_free && (m_q.size() > 0) && !bus.tx_busy;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_free      = 1'b1;
        m_age       = 0;
        m_busy_seen = 1'b0;
        exp_start   = 1'b0;
        exp_data    = 8'h00;
`ifdef UART_TXQ_DROP_CNT_EN
        m_drops     = 0;
`endif
    endtask

    // Advance one clock: step the model with this cycle's inputs, then emulate the transmitter.
    task automatic cycle();
        bit pop, push_ok, st;
        push_ok = bus.wr_en && (m_q.size() < DEPTH);
        pop     = model_will_pop();
`ifdef UART_TXQ_DROP_CNT_EN
        if (bus.wr_en && !push_ok && m_drops < 65535) m_drops++;
`endif
        exp_start = pop;
        if (pop) begin
            exp_data    = m_q.pop_front();
            m_free      = 1'b0;
            m_age       = 0;
            m_busy_seen = 1'b0;
        end else if (!m_free) begin
            if (m_busy_seen) begin
                if (!bus.tx_busy) m_free = 1'b1;
            end else if (bus.tx_busy) begin
                m_busy_seen = 1'b1;
            end else begin
                m_age++;
                if (m_age == 4) m_free = 1'b1;
            end
        end
        if (push_ok) m_q.push_back(bus.wr_data);
        st = bus.tx_start;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_connected && st) begin
            bus.tx_busy = 1'b1;
            tx_rem      = int'($urandom_range(frame_max, frame_min));
            rx_q.push_back(bus.tx_data);
        end else if (bus.tx_busy) begin
            if (tx_rem <= 1) begin
                bus.tx_busy = 1'b0;
                last_fall   = cyc;
            end else begin
                tx_rem--;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_busy = 1'b0;
        model_reset();
        @(posedge clk); #1; cyc++;
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0b exp 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 00", bus.tx_data); end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.full); end
`ifdef UART_TXQ_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL reset_drop_cnt got %0h exp 0", drop_cnt); end
`endif
        rst_n = 1'b1;
        repeat (3) cycle();
        checks++; if (bus.level !== 5'd0 || bus.tx_start !== 1'b0) begin errors++; $display("FAIL post_reset_idle level %0d start %0b exp 0 0", bus.level, bus.tx_start); end
    endtask

    task automatic test_single();
        int t0;
        rx_q.delete();
        frame_min = 10; frame_max = 10;
        t0 = cyc;
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        cycle();
        bus.wr_en = 1'b0;
        checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL single_level got %0d exp 1", bus.level); end
        for (int i = 0; i < 10 && bus.tx_start !== 1'b1; i++) cycle();
        checks++; if (cyc - t0 != 2) begin errors++; $display("FAIL single_latency got %0d exp 2", cyc - t0); end
        checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL single_data got %0h exp 55", bus.tx_data); end
        for (int i = 0; i < 30; i++) begin
            cycle();
            checks++; if (bus.tx_start !== exp_start) begin errors++; $display("FAIL single_start got %0b exp %0b", bus.tx_start, exp_start); end
        end
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL single_drained level %0d empty %0b exp 0 1", bus.level, bus.empty); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL single_rx got %0d bytes exp 1 byte 55", rx_q.size()); end
    endtask

    task automatic test_burst();
        logic [7:0] bytes [3];
        int peak, launches;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        rx_q.delete();
        frame_min = 8; frame_max = 8;
        peak = 0; launches = 0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = bytes[i];
            cycle();
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (int'(bus.level) > peak) peak = int'(bus.level);
            checks++; if (bus.level !== 5'(m_q.size())) begin errors++; $display("FAIL burst_level got %0d exp %0d", bus.level, m_q.size()); end
            checks++; if (bus.tx_start !== exp_start) begin errors++; $display("FAIL burst_start got %0b exp %0b", bus.tx_start, exp_start); end
            if (bus.tx_start === 1'b1) begin
                if (launches > 0) begin
                    checks++; if (cyc - last_fall != 2) begin errors++; $display("FAIL burst_gap got %0d exp 2", cyc - last_fall); end
                end
                launches++;
            end
            cycle();
        end
        checks++; if (peak != 2) begin errors++; $display("FAIL burst_peak got %0d exp 2", peak); end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL burst_count got %0d exp 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL burst_order[%0d] got %0h exp %0h", i, rx_q[i], bytes[i]); end
        end
    endtask

    task automatic test_overflow();
        rx_q.delete();
        frame_min = 30; frame_max = 30;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            cycle();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", bus.full); end
        checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", bus.level); end
`ifdef UART_TXQ_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 3", drop_cnt); end
`endif
        frame_min = 2; frame_max = 6;
        for (int i = 0; i < 300; i++) begin
            cycle();
            checks++; if (bus.level !== 5'(m_q.size())) begin errors++; $display("FAIL ovf_drain_level got %0d exp %0d", bus.level, m_q.size()); end
            checks++; if (bus.tx_data !== exp_data) begin errors++; $display("FAIL ovf_drain_data got %0h exp %0h", bus.tx_data, exp_data); end
        end
        checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL ovf_count got %0d exp 17", rx_q.size()); end
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL ovf_byte[%0d] got %0h exp %0h", i, rx_q[i], i); end
        end
    endtask

    task automatic test_full_pushpop();
        bit hit;
        frame_min = 40; frame_max = 40;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h80 + i);
            cycle();
        end
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
            if (model_will_pop()) begin
                checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL fullpp_pre_level got %0d exp 16", bus.level); end
                cycle();
                checks++; if (bus.level !== 5'd15 || bus.tx_start !== 1'b1) begin errors++; $display("FAIL fullpp_level got %0d start %0b exp 15 1", bus.level, bus.tx_start); end
                hit = 1'b1;
                break;
            end
            cycle();
        end
        bus.wr_en = 1'b0;
        checks++; if (!hit) begin errors++; $display("FAIL fullpp_timeout got no pop exp pop at level 16"); end
        frame_min = 3; frame_max = 3;
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (m_q.size() == 1 && model_will_pop()) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'hC3;
                cycle();
                bus.wr_en = 1'b0;
                checks++; if (bus.level !== 5'd1 || bus.tx_start !== 1'b1) begin errors++; $display("FAIL onepp_level got %0d start %0b exp 1 1", bus.level, bus.tx_start); end
                hit = 1'b1;
                break;
            end
            cycle();
        end
        checks++; if (!hit) begin errors++; $display("FAIL onepp_timeout got no pop exp pop at level 1"); end
        repeat (40) cycle();
        checks++; if (bus.level !== 5'd0 || bus.tx_busy !== 1'b0) begin errors++; $display("FAIL fullpp_drained level %0d busy %0b exp 0 0", bus.level, bus.tx_busy); end
    endtask

    task automatic test_lost_launch();
        int l1, l2;
        tx_connected = 1'b0;
        l1 = -1; l2 = -1;
        bus.wr_en = 1'b1; bus.wr_data = 8'h01; cycle();
        bus.wr_data = 8'h02; cycle();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.tx_start === 1'b1) begin
                if (l1 < 0) l1 = cyc;
                else if (l2 < 0) l2 = cyc;
            end
            checks++; if (bus.tx_start !== exp_start || bus.tx_data !== exp_data) begin errors++; $display("FAIL lost_launch start %0b data %0h exp %0b %0h", bus.tx_start, bus.tx_data, exp_start, exp_data); end
            cycle();
        end
        checks++; if (l1 < 0 || l2 - l1 != 5) begin errors++; $display("FAIL lost_launch_spacing got %0d exp 5", l2 - l1); end
        checks++; if (bus.tx_data !== 8'h02 || bus.level !== 5'd0) begin errors++; $display("FAIL lost_launch_end data %0h level %0d exp 02 0", bus.tx_data, bus.level); end
        tx_connected = 1'b1;
    endtask

    task automatic test_reset_mid();
        int rx_before;
        frame_min = 50; frame_max = 50;
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5; cycle();
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 8'(8'h10 + i); cycle();
        end
        bus.wr_en = 1'b0;
        repeat (5) cycle();
        checks++; if (bus.level !== 5'd5 || bus.tx_busy !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL rstmid_pre level %0d busy %0b data %0h exp 5 1 a5", bus.level, bus.tx_busy, bus.tx_data); end
        #3;
        rst_n = 1'b0;
        bus.tx_busy = 1'b0; tx_rem = 0;
        model_reset();
        #1;
        checks++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx start %0b data %0h exp 0 00", bus.tx_start, bus.tx_data); end
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rstmid_flags level %0d empty %0b full %0b exp 0 1 0", bus.level, bus.empty, bus.full); end
        @(posedge clk); #1; cyc++;
        rst_n = 1'b1;
        rx_before = rx_q.size();
        for (int i = 0; i < 30; i++) begin
            cycle();
            checks++; if (bus.tx_start !== 1'b0 || bus.level !== 5'd0) begin errors++; $display("FAIL rstmid_quiet start %0b level %0d exp 0 0", bus.tx_start, bus.level); end
        end
        checks++; if (rx_q.size() != rx_before) begin errors++; $display("FAIL rstmid_frames got %0d exp %0d", rx_q.size(), rx_before); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            if (i % 150 == 0) tx_connected = ($urandom_range(3, 0) != 0);
            frame_min = 1; frame_max = 10;
            bus.wr_en   = ($urandom_range(99, 0) < 45);
            bus.wr_data = 8'($urandom);
            cycle();
            checks++; if (bus.level !== 5'(m_q.size())) begin errors++; $display("FAIL rand_level got %0d exp %0d", bus.level, m_q.size()); end
            checks++; if (bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_flags empty %0b full %0b exp size %0d", bus.empty, bus.full, m_q.size()); end
            checks++; if (bus.tx_start !== exp_start) begin errors++; $display("FAIL rand_start got %0b exp %0b", bus.tx_start, exp_start); end
            checks++; if (bus.tx_data !== exp_data) begin errors++; $display("FAIL rand_data got %0h exp %0h", bus.tx_data, exp_data); end
        end
        bus.wr_en = 1'b0;
        tx_connected = 1'b1;
`ifdef UART_TXQ_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL rand_drop_cnt got %0d exp %0d", drop_cnt, m_drops); end
`endif
        repeat (300) cycle();
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL rand_drained level %0d empty %0b exp 0 1", bus.level, bus.empty); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pushpop();
        test_lost_launch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
